// File: rtl/ram_loader_if.sv
// Byte-stream, load-control and RAM write-port signals shared by ram_loader and its host.
// master = host side (drives start/bytes); slave = loader side.
interface ram_loader_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] baseAddr;
  logic [ADDRESS_WIDTH:0]   wordCount;
  logic [7:0]               byteIn;
  logic                     byteValid;
  logic                     byteReady;
  logic                     busy;
  logic                     done;
  logic                     memWEn;
  logic [ADDRESS_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0]    memData;

  modport master (
    output start, baseAddr, wordCount, byteIn, byteValid,
    input  byteReady, busy, done, memWEn, memAddr, memData
  );

  modport slave (
    input  start, baseAddr, wordCount, byteIn, byteValid,
    output byteReady, busy, done, memWEn, memAddr, memData
  );
endinterface

// File: rtl/ram_loader.sv
// Packs a little-endian byte stream into words and writes them to consecutive RAM addresses.
// Optional running checksum of written words: define LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ram_loader_if.slave           bus
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [ADDRESS_WIDTH:0] ONE      = (ADDRESS_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   remain_q, remain_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    sum_q, sum_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      idx_q    <= '0;
      word_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    word_d   = word_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          addr_d   = bus.baseAddr;
          remain_d = bus.wordCount;
          idx_d    = '0;
          word_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d    = '0;
`endif
          state_d  = (bus.wordCount != '0) ? StCollect : StDone;
        end
      end
      StCollect: begin
        if (bus.byteValid) begin
          for (int unsigned k = 0; k < BYTES; k++) begin
            if (idx_q == IDX_W'(k)) word_d[8*k +: 8] = bus.byteIn;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = StWrite;
        end
      end
      StWrite: begin
        // Address wraps naturally at 2^ADDRESS_WIDTH.
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - ONE;
        idx_d    = '0;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q + word_q;
`endif
        state_d  = (remain_q > ONE) ? StCollect : StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs come from registered state only.
  assign bus.byteReady = (state_q == StCollect);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.memWEn    = (state_q == StWrite);
  assign bus.memAddr   = addr_q;
  assign bus.memData   = word_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum      = sum_q;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus queues expected writes/done pulses, a monitor checks them.
module tb_ram_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bif ();
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  bit            exp_done[$];   // 1: done must follow a write; 0: zero-count load
  logic          prev_wen  = 1'b0;
  logic          prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not as expected", name);
  endtask

  // Monitor: every write and done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (bif.memWEn) begin
      check("ready_low_in_write", bif.byteReady, 0);
      if (exp_addr.size() == 0) fail("unexpected_write");
      else begin
        check("write_addr", bif.memAddr, exp_addr.pop_front());
        check("write_data", bif.memData, exp_data.pop_front());
      end
    end
    if (bif.done) begin
      if (exp_done.size() == 0) fail("unexpected_done");
      else if (exp_done.pop_front()) check("done_after_last_write", prev_wen, 1);
    end
    if (prev_done) check("busy_low_after_done", bif.busy, 0);
    prev_wen  <= bif.memWEn;
    prev_done <= bif.done;
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int t = 0;
    bif.byteIn    = b;
    bif.byteValid = 1'b1;
    while (!acc && t < 40) begin
      @(negedge clk);
      acc = bif.byteReady;
      @(posedge clk); #1;
      t++;
    end
    bif.byteValid = 1'b0;
    if (!acc) fail("byte_accept_timeout");
  endtask

  task automatic start_load(input logic [AW-1:0] base, input int count);
    bif.start     = 1'b1;
    bif.baseAddr  = base;
    bif.wordCount = (AW + 1)'(count);
    @(posedge clk); #1;
    bif.start     = 1'b0;
    @(negedge clk);
    check("busy_after_start", bif.busy, 1);
    check("ready_after_start", bif.byteReady, (count != 0) ? 1 : 0);
    if (count == 0) check("zero_count_done", bif.done, 1);
    @(posedge clk); #1;
  endtask

  // Reference: word i = bytes[4i..4i+3] little-endian at (base+i) mod 2^AW.
  // gap < 0 selects random gaps; poke pulses start after the first byte.
  task automatic run_load(input logic [AW-1:0] base, input int count, input logic [7:0] bytes[$],
                          input int gap, input bit poke);
    logic [DW-1:0] w;
    logic [DW-1:0] sum = '0;
    int g;
    int waited = 0;
    for (int i = 0; i < count; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) w = w | (DW'(bytes[4*i+k]) << (8 * k));
      exp_addr.push_back(AW'(int'(base) + i));
      exp_data.push_back(w);
      sum = sum + w;
    end
    exp_done.push_back(count != 0);
    start_load(base, count);
    for (int n = 0; n < 4 * count; n++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (n % 4 != 0) begin
        repeat (g) begin
          @(negedge clk);
          check("ready_during_gap", bif.byteReady, 1);
          @(posedge clk); #1;
        end
      end
      send_byte(bytes[n]);
      if (poke && n == 0) begin
        bif.start     = 1'b1;
        bif.baseAddr  = base ^ 12'h155;
        bif.wordCount = 13'd1;
        @(posedge clk); #1;
        bif.start     = 1'b0;
      end
    end
    while ((exp_done.size() != 0 || exp_addr.size() != 0) && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 40) fail("load_completion_timeout");
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum, sum);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byteReady"}, bif.byteReady, 0);
    check({tag, "_busy"}, bif.busy, 0);
    check({tag, "_done"}, bif.done, 0);
    check({tag, "_memWEn"}, bif.memWEn, 0);
    check({tag, "_memAddr"}, bif.memAddr, 0);
    check({tag, "_memData"}, bif.memData, 0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    logic [7:0] bq[$];
    logic [7:0] basic[$];
    int cnt;
    logic [AW-1:0] base;
    basic = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bif.start = 1'b0; bif.baseAddr = '0; bif.wordCount = '0;
    bif.byteIn = '0; bif.byteValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_load(12'h010, 2, basic, 0, 1'b0);

    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(12'h100, 1, bq, 2, 1'b0);

    bq = '{};
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    run_load(12'hFFF, 2, bq, -1, 1'b0);

    bq = '{};
    run_load(12'h200, 0, bq, 0, 1'b0);

    // Reset after two bytes of word 0: nothing may be written.
    start_load(12'h020, 2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_load(12'h010, 2, basic, 0, 1'b0);

    bq = '{};
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
    run_load(12'h300, 3, bq, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      cnt  = int'($urandom_range(1, 3));
      base = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(12'hFFD, 12'hFFF)) : AW'($urandom);
      bq = '{};
      for (int i = 0; i < 4 * cnt; i++) bq.push_back(8'($urandom));
      run_load(base, cnt, bq, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("leftover_writes", exp_addr.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
